// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and the hardwired zero-register index.
package regfile_mp_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and issue bundle for the multi-port register file.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic [CW-1:0]       pend_cnt;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
        input  rd_data, rd_busy, iss_ready, pend_cnt
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
        output rd_data, rd_busy, iss_ready, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, WAW issue stall and pending count.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    output logic [NREGS-1:0]  busy,
    output logic [CW-1:0]     pend_cnt
);
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    assign iss_ready = !busy[iss_rd];
    // clears first, then an accepted issue re-marks its register as a new producer
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWR; k++)
            if (wr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
        if (iss_valid && iss_ready && iss_rd != AW'(REG_ZERO)) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
        cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with issue scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    a;
    regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .iss_ready (bus.iss_ready),
        .busy      (busy),
        .pend_cnt  (bus.pend_cnt)
    );
    // later ports are assigned last, so the highest index wins a collision
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) regs <= '{default: '0};
        else
            for (int k = 0; k < NWR; k++)
                if (bus.wr_en[k] && bus.wr_addr[k*AW +: AW] != AW'(REG_ZERO))
                    regs[bus.wr_addr[k*AW +: AW]] <= bus.wr_data[k*XLEN +: XLEN];
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        a = '0;
        for (int k = 0; k < NRD; k++) begin
            a = bus.rd_addr[k*AW +: AW];
            bus.rd_data[k*XLEN +: XLEN] = (a == AW'(REG_ZERO)) ? '0 : regs[a];
            bus.rd_busy[k] = busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++)
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a && a != AW'(REG_ZERO)) begin
                    bus.rd_data[k*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
                    bus.rd_busy[k] = 1'b0;
                end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, reset sequence and randomized model check of regfile_mp.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra;
        logic [31:0] ed;
        logic        eb;
        logic        er;
        int          ec;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    logic [31:0] mregs [32];
    bit          mbusy [32];
    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  we;
    logic        iv;
    logic [4:0]  ir;
    logic [31:0] ed;
    logic        eb;
    logic        acc;
    int          ec;
    regfile_mp_if bus();
    regfile_mp dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic vec_t mk(input logic [1:0] we_i, input logic [4:0] wa0_i, input logic [31:0] wd0_i,
                                input logic [4:0] wa1_i, input logic [31:0] wd1_i, input logic iv_i,
                                input logic [4:0] ir_i, input logic [4:0] ra_i, input logic [31:0] ed_i,
                                input logic eb_i, input logic er_i, input int ec_i);
        return '{we_i, wa0_i, wd0_i, wa1_i, wd1_i, iv_i, ir_i, ra_i, ed_i, eb_i, er_i, ec_i};
    endfunction
    task automatic drive(input logic [1:0] we_i, input logic [4:0] wa0_i, input logic [31:0] wd0_i,
                         input logic [4:0] wa1_i, input logic [31:0] wd1_i, input logic iv_i,
                         input logic [4:0] ir_i, input logic [4:0] ra0_i, input logic [4:0] ra1_i);
        bus.wr_en     = we_i;
        bus.wr_addr   = {wa1_i, wa0_i};
        bus.wr_data   = {wd1_i, wd0_i};
        bus.iss_valid = iv_i;
        bus.iss_rd    = ir_i;
        bus.rd_addr   = {ra1_i, ra0_i};
    endtask
    initial begin
        //            we    wa0 wd0           wa1 wd1    iv ir ra  data                     busy   rdy cnt
        tbl.push_back(mk(2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0, 1, 32'h0,                   0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     0, 0, 5, 32'hDEADBEEF,            0,     1, 0));
        tbl.push_back(mk(2'b01, 0, 32'h1234,     0, 0,     0, 0, 5, 32'hDEADBEEF,            0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 32'h0,                   0,     1, 0));
        tbl.push_back(mk(2'b11, 7, 32'h11,       7, 32'h22, 0, 0, 5, 32'hDEADBEEF,           0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     0, 0, 7, 32'h22,                  0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     1, 3, 3, 32'h0,                   0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     1, 3, 3, 32'h0,                   1,     0, 1));
        tbl.push_back(mk(2'b01, 3, 32'hAA,       0, 0,     0, 3, 3, BYP ? 32'hAA : 32'h0,    !BYP,  0, 1));
        tbl.push_back(mk(2'b01, 3, 32'hBB,       0, 0,     1, 3, 3, BYP ? 32'hBB : 32'hAA,   0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     0, 3, 3, 32'hBB,                  1,     0, 1));
        tbl.push_back(mk(2'b01, 3, 32'hCC,       0, 0,     0, 0, 9, 32'h0,                   0,     1, 1));
        tbl.push_back(mk(2'b01, 9, 32'hCAFE,     0, 0,     0, 0, 9, BYP ? 32'hCAFE : 32'h0,  0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     1, 0, 9, 32'hCAFE,                0,     1, 0));
        tbl.push_back(mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 32'h0,                   0,     1, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 5, 9);
        #1;
        chk("por_rd0", bus.rd_data[31:0], 0);
        chk("por_cnt", 32'(bus.pend_cnt), 0);
        chk("por_rdy", 32'(bus.iss_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1, tbl[i].iv, tbl[i].ir, tbl[i].ra, 0);
            #1;
            chk($sformatf("tbl%0d_data", i), bus.rd_data[31:0], tbl[i].ed);
            chk($sformatf("tbl%0d_busy", i), 32'(bus.rd_busy[0]), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_rdy", i), 32'(bus.iss_ready), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.pend_cnt), 32'(tbl[i].ec));
        end
        // mid-run reset with a pending register, checked before any clock edge
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 4, 4, 5);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 4, 4, 5);
        #1;
        chk("pre_rst_busy", 32'(bus.rd_busy[0]), 1);
        chk("pre_rst_cnt", 32'(bus.pend_cnt), 1);
        chk("pre_rst_rd1", bus.rd_data[63:32], 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rd0", bus.rd_data[31:0], 0);
        chk("rst_rd1", bus.rd_data[63:32], 0);
        chk("rst_busy", 32'(bus.rd_busy[0]), 0);
        chk("rst_cnt", 32'(bus.pend_cnt), 0);
        chk("rst_rdy", 32'(bus.iss_ready), 1);
        drive(2'b01, 6, 32'h77, 0, 0, 1, 6, 6, 9);
        @(negedge clk);
        #1;
        chk("rst_wr_ignored", bus.rd_data[31:0], 0);
        chk("rst_iss_ignored", 32'(bus.pend_cnt), 0);
        chk("rst_rd9", bus.rd_data[63:32], 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            mregs[r] = '0;
            mbusy[r] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            we = 2'($urandom);
            iv = 1'($urandom);
            ir = 5'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                wa[p] = 5'($urandom_range(0, 7));
                wd[p] = $urandom;
                ra[p] = 5'($urandom_range(0, 7));
            end
            drive(we, wa[0], wd[0], wa[1], wd[1], iv, ir, ra[0], ra[1]);
            #1;
            for (int p = 0; p < 2; p++) begin
                ed = (ra[p] == 0) ? 32'h0 : mregs[ra[p]];
                eb = (ra[p] == 0) ? 1'b0 : mbusy[ra[p]];
                if (BYP && ra[p] != 0)
                    for (int w = 0; w < 2; w++)
                        if (we[w] && wa[w] == ra[p]) begin
                            ed = wd[w];
                            eb = 1'b0;
                        end
                chk($sformatf("rnd%0d_data%0d", c, p), bus.rd_data[p*32 +: 32], ed);
                chk($sformatf("rnd%0d_busy%0d", c, p), 32'(bus.rd_busy[p]), 32'(eb));
            end
            ec = 0;
            for (int r = 0; r < 32; r++) ec += int'(mbusy[r]);
            chk($sformatf("rnd%0d_rdy", c), 32'(bus.iss_ready), 32'(!mbusy[ir]));
            chk($sformatf("rnd%0d_cnt", c), 32'(bus.pend_cnt), 32'(ec));
            acc = iv && ir != 0 && !mbusy[ir];
            for (int w = 0; w < 2; w++)
                if (we[w]) begin
                    if (wa[w] != 0) mregs[wa[w]] = wd[w];
                    mbusy[wa[w]] = 1'b0;
                end
            if (acc) mbusy[ir] = 1'b1;
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read-port count (>=1).
REQ-004 SHALL have parameter NWR, default 2, write-port count (>=1).
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr  input  NRD*AW  packed read addresses, port k at [k*AW +: AW].
REQ-008 SHALL have port rd_data  output  NRD*XLEN  packed read data.
REQ-009 SHALL have port rd_busy  output  NRD  per-read-port pending flag of addressed register.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NWR*AW  packed write addresses.
REQ-012 SHALL have port wr_data  input  NWR*XLEN  packed write data.
REQ-013 SHALL have port iss_valid  input  1  issue request: mark iss_rd pending.
REQ-014 SHALL have port iss_rd  input  AW  destination register of issuing instruction.
REQ-015 SHALL have port iss_ready  output  1  issue accepted this cycle.
REQ-016 SHALL have port pend_cnt  output  clog2(NREGS+1)  number of registers currently pending.

Function
REQ-017 SHALL return rd_data combinationally from the register array; address 0 always reads 0 and rd_busy 0.
REQ-018 SHALL write wr_data into wr_addr at the clock edge when wr_en is high and wr_addr != 0; writes to 0 are discarded.
REQ-019 SHALL resolve two write ports targeting the same register in one cycle by highest port index winning.
REQ-020 SHALL clear the busy bit of a register on any enabled write to it.
REQ-021 SHALL drive iss_ready = !busy[iss_rd] (WAW stall); iss_rd = 0 always ready.
REQ-022 SHALL set busy[iss_rd] at the edge when iss_valid && iss_ready && iss_rd != 0; iss_rd = 0 sets nothing.
REQ-023 SHALL give set priority over clear when an accepted issue and a write target the same register in the same cycle (new producer).
REQ-024 SHALL compute iss_ready from current busy state only, not same-cycle writes (no combinational write-to-issue path).
REQ-025 SHALL keep pend_cnt equal to the population count of busy bits, updated registered with the busy vector, never exceeding NREGS-1.

Reset
REQ-026 SHALL asynchronously clear all registers to 0, all busy bits to 0, pend_cnt to 0 while rst_n low; outputs then rd_data=0, rd_busy=0, iss_ready=1.
REQ-027 SHALL ignore writes and issues while rst_n low; reset asserted mid-operation discards pending state immediately.

Configuration
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle wr_data (highest matching write port, nonzero address) to rd_data and force rd_busy 0 for that read port.
REQ-029 SHALL, without REGFILE_BYPASS_EN, return the pre-edge array value and pre-edge busy bit on same-cycle read/write collision.

Structure
REQ-030 SHALL take REG_ZERO index and default XLEN/NREGS constants from the shared defines package.
REQ-031 SHALL place busy-bit tracking, iss_ready and pend_cnt in sub-module regfile_scoreboard; data array and bypass stay in regfile_mp.

Verification
REQ-032 SHALL check reset: assert rst_n low mid-run -> all rd_data 0, pend_cnt 0, iss_ready 1 without a clock edge.
REQ-033 SHALL check write/read: wr port0 x5=0xDEADBEEF, next cycle rd_addr0=5 -> 0xDEADBEEF; write x0=0x1234 -> read x0 = 0.
REQ-034 SHALL check port conflict: port0 x7=0x11, port1 x7=0x22 same cycle -> x7 reads 0x22.
REQ-035 SHALL check scoreboard: issue x3 -> rd_busy 1, pend_cnt 1, second issue x3 iss_ready 0; write x3 -> busy 0, pend_cnt 0; issue+write x3 same cycle -> busy remains 1.
REQ-036 SHALL check bypass: write x9=0xCAFE while reading x9 -> rd_data 0xCAFE with REGFILE_BYPASS_EN, old value (0) without.
